// File: rtl/fp_div_sqrt_unit.sv
// ---------------------------------------------------------------------------
// fp_div_sqrt_unit
//
// Iterative fixed-point divide / square-root unit for signed two's complement
// Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS operands.
//   op = 0 : result = a / b   (restoring long division, one bit per cycle)
//   op = 1 : result = sqrt(a) (non-restoring digit-by-digit, one bit per cycle)
// Divide-by-zero and negative-sqrt requests skip the iterative phase and
// report directly with the matching status code.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  request handshake (ready only while idle)
//   op, a, b             operation select, dividend/radicand, divisor
//   out_valid / out_ready result handshake (result held until accepted)
//   result               quotient or root (DATA_WIDTH bits)
//   status               00 ok, 01 div-by-zero, 10 negative sqrt, 11 saturated
// ---------------------------------------------------------------------------
module fp_div_sqrt_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [1:0]            status
);

  localparam int DW        = DATA_WIDTH;
  localparam int FB        = FRAC_BITS;
  localparam int N         = DW + FB;      // scaled dividend / radicand width
  localparam int DIV_ITER  = N;
  localparam int SQRT_ITER = N / 2;
  localparam int RW        = N / 2;        // root width
  localparam int SW        = RW + 5;       // signed partial remainder, with headroom
  localparam int CW        = $clog2(DIV_ITER + 1);

  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [N-1:0]  POS_LIM = {{(FB+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [N-1:0]  NEG_LIM = {{FB{1'b0}}, 1'b1, {(DW-1){1'b0}}};

  // The sqrt pairs radicand bits two at a time and the root must fit in the
  // result word, so both width relations are checked at elaboration.
  generate
    if ((DATA_WIDTH + FRAC_BITS) % 2 != 0) begin : g_odd_width
      $error("fp_div_sqrt_unit: DATA_WIDTH+FRAC_BITS must be even");
    end
    if (FRAC_BITS >= DATA_WIDTH) begin : g_frac_too_wide
      $error("fp_div_sqrt_unit: FRAC_BITS must be smaller than DATA_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_q, op_d;
  logic            neg_q, neg_d;
  logic [DW-1:0]   div_q, div_d;
  logic [N-1:0]    work_q, work_d;     // dividend/quotient or radicand shifter
  logic [DW-1:0]   drem_q, drem_d;
  logic [SW-1:0]   srem_q, srem_d;
  logic [RW-1:0]   root_q, root_d;
  logic [DW-1:0]   result_q, result_d;
  logic [1:0]      status_q, status_d;

  logic [DW-1:0]   abs_a, abs_b;
  logic [DW+1:0]   d_trial;
  logic [N-1:0]    quo_next;
  logic [DW-1:0]   drem_next;
  logic [DW-1:0]   div_res;
  logic [1:0]      div_st;
  logic [SW-1:0]   s_shift, s_new;
  logic [RW-1:0]   root_next;
  logic [CW-1:0]   last_cnt;

  // Magnitudes are DW-bit unsigned, so the most negative value maps exactly.
  assign abs_a = a[DW-1] ? (~a + 1'b1) : a;
  assign abs_b = b[DW-1] ? (~b + 1'b1) : b;

  // Restoring divide step: bring the next dividend bit into the remainder and
  // subtract the divisor; the top bit of the trial is the borrow.
  assign d_trial   = {1'b0, drem_q, work_q[N-1]} - {2'b00, div_q};
  assign quo_next  = {work_q[N-2:0], ~d_trial[DW+1]};
  assign drem_next = d_trial[DW+1] ? {drem_q[DW-2:0], work_q[N-1]} : d_trial[DW-1:0];

  // Final quotient sign/saturation; a negative quotient may reach 2^(DW-1).
  always_comb begin
    div_res = neg_q ? -quo_next[DW-1:0] : quo_next[DW-1:0];
    div_st  = 2'b00;
    if (!neg_q && (quo_next > POS_LIM)) begin
      div_res = MAX_POS;
      div_st  = 2'b11;
    end else if (neg_q && (quo_next > NEG_LIM)) begin
      div_res = MIN_NEG;
      div_st  = 2'b11;
    end
  end

  // Non-restoring sqrt step: a negative partial remainder adds (4*root+3)
  // instead of restoring, and the new root bit is the sign of the result.
  assign s_shift   = {srem_q[SW-3:0], work_q[N-1:N-2]};
  assign s_new     = srem_q[SW-1] ? (s_shift + {{(SW-RW-2){1'b0}}, root_q, 2'b11})
                                  : (s_shift - {{(SW-RW-2){1'b0}}, root_q, 2'b01});
  assign root_next = {root_q[RW-2:0], ~s_new[SW-1]};

  assign last_cnt = op_q ? CW'(SQRT_ITER - 1) : CW'(DIV_ITER - 1);

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    div_d    = div_q;
    work_d   = work_q;
    drem_d   = drem_q;
    srem_d   = srem_q;
    root_d   = root_q;
    result_d = result_q;
    status_d = status_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op;
          cnt_d = '0;
          if (!op) begin
            if (b == '0) begin
              result_d = a[DW-1] ? MIN_NEG : MAX_POS;
              status_d = 2'b01;
              state_d  = DONE;
            end else begin
              neg_d   = a[DW-1] ^ b[DW-1];
              div_d   = abs_b;
              work_d  = {abs_a, {FB{1'b0}}};
              drem_d  = '0;
              state_d = CALC;
            end
          end else begin
            if (a[DW-1]) begin
              result_d = '0;
              status_d = 2'b10;
              state_d  = DONE;
            end else begin
              work_d  = {a, {FB{1'b0}}};
              srem_d  = '0;
              root_d  = '0;
              state_d = CALC;
            end
          end
        end
      end

      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q) begin
          srem_d = s_new;
          root_d = root_next;
          work_d = {work_q[N-3:0], 2'b00};
        end else begin
          drem_d = drem_next;
          work_d = quo_next;
        end
        if (cnt_q == last_cnt) begin
          cnt_d   = '0;
          state_d = DONE;
          if (op_q) begin
            result_d = {{(DW-RW){1'b0}}, root_next};
            status_d = 2'b00;
          end else begin
            result_d = div_res;
            status_d = div_st;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      neg_q    <= 1'b0;
      div_q    <= '0;
      work_q   <= '0;
      drem_q   <= '0;
      srem_q   <= '0;
      root_q   <= '0;
      result_q <= '0;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      div_q    <= div_d;
      work_q   <= work_d;
      drem_q   <= drem_d;
      srem_q   <= srem_d;
      root_q   <= root_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign result = result_q;
  assign status = status_q;

endmodule

// File: tb/tb_fp_div_sqrt_unit.sv
// Directed bench for fp_div_sqrt_unit (DATA_WIDTH=32, FRAC_BITS=16).
module tb_fp_div_sqrt_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [1:0]  status;

  int totalCount = 0;
  int badCount   = 0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic [1:0]  expSt;
    int          expLat;
  } vec_t;

  vec_t vecs [16];

  fp_div_sqrt_unit #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .status    (status)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one request, then count cycles until out_valid (bounded).
  task automatic applyStimulus(input logic opIn, input logic [31:0] aIn,
                               input logic [31:0] bIn, output int lat);
    op       = opIn;
    a        = aIn;
    b        = bIn;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0BAD_F00D;
    op       = ~opIn;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      totalCount++;
      badCount++;
      $display("[TB] FAIL timeout: out_valid never rose after %0d cycles", lat);
    end
  endtask

  // Accept the result and confirm the unit returns to idle.
  task automatic releaseResult(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, ".validAfter"}, {31'b0, out_valid}, 32'd0);
    checkOutput({name, ".readyAfter"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  seen;
    string nm;

    vecs[0]  = '{1'b1, 32'h0004_0000, 32'h0, 32'h0002_0000, 2'b00, 25};
    vecs[1]  = '{1'b1, 32'h0002_0000, 32'h0, 32'h0001_6A09, 2'b00, 25};
    vecs[2]  = '{1'b0, 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 2'b00, 49};
    vecs[3]  = '{1'b0, 32'hFFF8_8000, 32'h0002_0000, 32'hFFFC_4000, 2'b00, 49};
    vecs[4]  = '{1'b0, 32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 2'b01, 1};
    vecs[5]  = '{1'b1, 32'hFFFF_0000, 32'h0, 32'h0000_0000, 2'b10, 1};
    vecs[6]  = '{1'b0, 32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 2'b11, 49};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0000_FFFF, 32'h8000_0000, 2'b11, 49};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'h0, 32'h0000_0000, 2'b00, 25};
    vecs[9]  = '{1'b0, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 2'b01, 1};
    vecs[10] = '{1'b0, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 2'b00, 49};
    vecs[11] = '{1'b0, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000, 2'b00, 49};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 2'b00, 49};
    vecs[13] = '{1'b0, 32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 2'b00, 49};
    vecs[14] = '{1'b0, 32'h0001_0000, 32'h0000_0002, 32'h7FFF_FFFF, 2'b11, 49};
    vecs[15] = '{1'b1, 32'h7FFF_FFFF, 32'h0, 32'h00B5_04F3, 2'b00, 25};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 1'b0;
    a         = '0;
    b         = '0;

    // Reset state
    #2;
    checkOutput("reset.out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset.result", result, 32'd0);
    checkOutput("reset.status", {30'b0, status}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset.in_ready", {31'b0, in_ready}, 32'd1);

    // Table of directed vectors
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      nm = $sformatf("vec%0d", i);
      checkOutput({nm, ".result"}, result, vecs[i].expRes);
      checkOutput({nm, ".status"}, {30'b0, status}, {30'b0, vecs[i].expSt});
      checkOutput({nm, ".latency"}, 32'(lat), 32'(vecs[i].expLat));
      releaseResult(nm);
    end

    // Back-pressure: result held while out_ready stays low, requests ignored
    applyStimulus(1'b0, 32'h0001_0000, 32'h0003_0000, lat);
    checkOutput("hold.latency", 32'(lat), 32'd49);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        in_valid = 1'b1;
        op       = 1'b1;
        a        = 32'h0009_0000;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      nm = $sformatf("hold%0d", c);
      checkOutput({nm, ".result"}, result, 32'h0000_5555);
      checkOutput({nm, ".status"}, {30'b0, status}, 32'd0);
      checkOutput({nm, ".in_ready"}, {31'b0, in_ready}, 32'd0);
      checkOutput({nm, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    end
    // Request present on the completing handshake cycle must not be taken
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 1'b1;
    a         = 32'h0009_0000;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("hold.release.in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("hold.release.out_valid", {31'b0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold.idle.in_ready", {31'b0, in_ready}, 32'd1);

    // Reset in the middle of a divide aborts it
    op       = 1'b0;
    a        = 32'h0001_0000;
    b        = 32'h0003_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort.out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("abort.in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("abort.noResult", {31'b0, seen}, 32'd0);
    applyStimulus(1'b1, 32'h0009_0000, 32'h0, lat);
    checkOutput("abort.next.result", result, 32'h0003_0000);
    checkOutput("abort.next.status", {30'b0, status}, 32'd0);
    checkOutput("abort.next.latency", 32'(lat), 32'd25);
    releaseResult("abort.next");

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/fp_div_sqrt_unit.md
FP_DIV_SQRT_UNIT -- requirements
Module: fp_div_sqrt_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits (signed two's complement).
REQ-002 SHALL have parameter FRAC_BITS, default 16, fractional bits of the Q format; DATA_WIDTH+FRAC_BITS SHALL be even (elaboration error otherwise).
REQ-003 SHALL use one clock; reset is asynchronous and active-high:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
REQ-004 SHALL have:
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request
- op  input  1  0 = divide a/b, 1 = square root of a
- a  input  DATA_WIDTH  dividend / radicand
- b  input  DATA_WIDTH  divisor (ignored for sqrt)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  DATA_WIDTH  quotient or root
- status  output  2  00 ok, 01 divide-by-zero, 10 negative sqrt, 11 overflow/saturated

Function
REQ-005 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-006 SHALL accept a request on a cycle with in_valid & in_ready, capturing op, a, b; IDLE->CALC (normal case) or IDLE->DONE (special case, REQ-011/012).
REQ-007 Divide SHALL compute trunc-toward-zero of (|a|<<FRAC_BITS)/|b| by radix-2 restoring long division, one quotient bit per cycle, DIV_ITER = DATA_WIDTH+FRAC_BITS cycles in CALC.
REQ-008 Divide sign SHALL be sign(a) XOR sign(b); magnitudes SHALL be formed as DATA_WIDTH-bit unsigned, so -2^(DATA_WIDTH-1) is handled exactly; a zero quotient SHALL be 0 regardless of sign.
REQ-009 Divide result magnitude above 2^(DATA_WIDTH-1)-1 (positive) or above 2^(DATA_WIDTH-1) (negative) SHALL saturate to 2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1) respectively, with status 11.
REQ-010 Sqrt SHALL compute floor(sqrt(a * 2^FRAC_BITS)) by digit-by-digit (non-restoring) method, one root bit per cycle, SQRT_ITER = (DATA_WIDTH+FRAC_BITS)/2 cycles in CALC; result zero-extended to DATA_WIDTH; status 00.
REQ-011 Divide with b = 0 SHALL bypass CALC: result 2^(DATA_WIDTH-1)-1 if a >= 0, else -2^(DATA_WIDTH-1); status 01.
REQ-012 Sqrt with a < 0 SHALL bypass CALC: result 0, status 10; sqrt of a = 0 SHALL take the normal path and return 0, status 00.
REQ-013 Latency: request accepted at cycle T -> out_valid high at T+ITER+1 (normal), T+1 (special case).
REQ-014 An iteration counter SHALL count 0..ITER-1 in CALC; CALC->DONE when counter = ITER-1.
REQ-015 In DONE, out_valid = 1 and result/status SHALL be held stable until out_ready = 1; DONE->IDLE on out_valid & out_ready; no new request accepted in that same cycle.
REQ-016 in_valid, a, b, op SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.

Reset
REQ-017 rst SHALL asynchronously force state IDLE, counter 0, out_valid 0, result 0, status 00; in_ready = 1 from the first clock edge after rst deasserts.
REQ-018 rst asserted during CALC or DONE SHALL abort the operation with no result output; the next accepted request SHALL compute correctly.

Verification (DATA_WIDTH=32, FRAC_BITS=16; DIV_ITER=48, SQRT_ITER=24)
REQ-019 sqrt a=0x0004_0000 -> result 0x0002_0000, status 00, out_valid at T+25; sqrt a=0x0002_0000 -> 0x0001_6A09.
REQ-020 divide 0x0001_0000/0x0003_0000 -> 0x0000_5555 at T+49; divide 0xFFF8_8000/0x0002_0000 -> 0xFFFC_4000, status 00.
REQ-021 divide 0x0001_0000/0 -> 0x7FFF_FFFF, status 01, out_valid at T+1; sqrt 0xFFFF_0000 -> 0x0000_0000, status 10, at T+1.
REQ-022 divide 0x7FFF_0000/0x0000_0001 -> 0x7FFF_FFFF, status 11; divide 0x8000_0000/0x0000_FFFF -> 0x8000_0000, status 11.
REQ-023 out_ready held low 10 cycles after out_valid -> result/status stable, in_ready 0 throughout; in_valid pulsed in that window is not accepted.
REQ-024 rst pulsed at cycle 20 of a divide -> out_valid never asserted for it; next sqrt 0x0009_0000 -> 0x0003_0000 with correct T+25 latency.
